// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared add/sub/mul/div unit with a restoring divider.
// Optional: define ALU_DIV_EXACT_EN to flag divides that leave a non-zero remainder.
module alu_arbiter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on the rising edge where valid and ready are both high;
  // ready never depends on the same-cycle transfer and valid/payload are held until it happens.

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_err_q;

  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] exec_res;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             div_last;
  logic             div_err;

  // On a tie the requester that did not win last time is granted.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready = rst && (state_q == IDLE) && grant0;
  assign req1_ready = rst && (state_q == IDLE) && grant1;

  always_comb begin
    exec_res = '0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_MUL:  exec_res = a_q * b_q;
      default: exec_res = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit and subtract the divisor if it fits.
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, b_q});
  assign rem_d    = ge ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
  assign quo_d    = {quo_q[WIDTH-2:0], ge};
  assign div_last = (cnt_q == CW'(WIDTH - 1));

`ifdef ALU_DIV_EXACT_EN
  assign div_err = (rem_d != '0);
`else
  assign div_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_ready) begin
            op_q         <= req0_op;
            a_q          <= req0_a;
            b_q          <= req0_b;
            id_q         <= 1'b0;
            last_grant_q <= 1'b0;
            state_q      <= EXEC;
          end else if (req1_ready) begin
            op_q         <= req1_op;
            a_q          <= req1_a;
            b_q          <= req1_b;
            id_q         <= 1'b1;
            last_grant_q <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == OP_DIV) begin
            if (b_q == '0) begin
              rsp_result_q <= '1;
              rsp_err_q    <= 1'b1;
              rsp_id_q     <= id_q;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end else begin
              rem_q   <= '0;
              quo_q   <= a_q;
              cnt_q   <= '0;
              state_q <= DIV;
            end
          end else begin
            rsp_result_q <= exec_res;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= id_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (div_last) begin
            rsp_result_q <= quo_d;
            rsp_err_q    <= div_err;
            rsp_id_q     <= id_q;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, each op, round-robin, divide cases, backpressure, reset mid-divide.
module tb_alu_arbiter;

  localparam int W = 10;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0] rsp_result;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected responses packed as {id, err, result}.
  logic [W+1:0] exp_q[$];
  logic         acc_q[$];

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (req0_valid && req0_ready) acc_q.push_back(1'b0);
    if (req1_valid && req1_ready) acc_q.push_back(1'b1);
  end

  always @(posedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_rsp observed=%0h expected=none", {rsp_id, rsp_err, rsp_result});
      end else begin
        chk("rsp", 32'({rsp_id, rsp_err, rsp_result}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input bit id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    if (id == 1'b0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=no_ready expected=ready");
    end
    @(negedge clk);
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  // Latency = clock edges from the accept edge to the edge that first samples rsp_valid high.
  task automatic wait_rsp(output int lat);
    int k;
    k = 0;
    while (!rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    lat = k + 1;
  endtask

  task automatic wait_acc(input int cnt);
    int n;
    n = 0;
    while (acc_q.size() < cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("acc_count", 32'(acc_q.size()), 32'(cnt));
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 10'd8; req0_b = 10'd16;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    #2 rst = 1'b0;

    // Reset with req0 already requesting.
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_req0_ready", 32'(req0_ready), 32'd1);
    exp_q.push_back({1'b0, 1'b0, 10'd24});
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(lat);
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_id", 32'(rsp_id), 32'd0);

    exp_q.push_back({1'b1, 1'b0, 10'd276});
    send(1'b1, 2'b10, 10'd13, 10'd100);
    wait_rsp(lat);
    chk("mul_lat", 32'(lat), 32'd2);

    exp_q.push_back({1'b1, 1'b1, 10'd1023});
    send(1'b1, 2'b11, 10'd24, 10'd0);
    wait_rsp(lat);
    chk("div0_lat", 32'(lat), 32'd2);

`ifdef ALU_DIV_EXACT_EN
    exp_q.push_back({1'b0, 1'b1, 10'd142});
`else
    exp_q.push_back({1'b0, 1'b0, 10'd142});
`endif
    send(1'b0, 2'b11, 10'd1000, 10'd7);
    wait_rsp(lat);
    chk("div_lat", 32'(lat), 32'd12);

    exp_q.push_back({1'b1, 1'b0, 10'd8});
    send(1'b1, 2'b11, 10'd24, 10'd3);
    wait_rsp(lat);
    chk("div_exact_lat", 32'(lat), 32'd12);

    exp_q.push_back({1'b0, 1'b0, 10'd1022});
    send(1'b0, 2'b01, 10'd3, 10'd5);
    wait_rsp(lat);
    chk("sub_lat", 32'(lat), 32'd2);
    wait_empty();

    // Round-robin from reset with both requesters held valid.
    reset_pulse();
    acc_q.delete();
    req0_op = 2'b00; req0_a = 10'd1;  req0_b = 10'd2;
    req1_op = 2'b00; req1_a = 10'd10; req1_b = 10'd20;
    exp_q.push_back({1'b0, 1'b0, 10'd3});
    exp_q.push_back({1'b1, 1'b0, 10'd30});
    exp_q.push_back({1'b0, 1'b0, 10'd3});
    exp_q.push_back({1'b1, 1'b0, 10'd30});
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_acc(4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_empty();
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(acc_q[i]), 32'(i % 2));

    // Sole requester is granted back to back.
    @(negedge clk);
    acc_q.delete();
    req1_op = 2'b00; req1_a = 10'd7; req1_b = 10'd8;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 1'b0, 10'd15});
    req1_valid = 1'b1;
    wait_acc(3);
    req1_valid = 1'b0;
    wait_empty();
    for (int i = 0; i < 3; i++) chk($sformatf("sole_grant%0d", i), 32'(acc_q[i]), 32'd1);

    // Backpressure: response held while both requesters wait.
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 10'd11});
    send(1'b0, 2'b00, 10'd5, 10'd6);
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 32'd2);
    acc_q.delete();
    req0_op = 2'b00; req0_a = 10'd1;   req0_b = 10'd1;
    req1_op = 2'b00; req1_a = 10'd100; req1_b = 10'd200;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (5) begin
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", 32'(rsp_result), 32'd11);
      chk("bp_rsp_id", 32'(rsp_id), 32'd0);
      chk("bp_req0_ready", 32'(req0_ready), 32'd0);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_no_accept", 32'(acc_q.size()), 32'd0);
    exp_q.push_back({1'b1, 1'b0, 10'd300});
    exp_q.push_back({1'b0, 1'b0, 10'd2});
    rsp_ready = 1'b1;
    wait_acc(2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_empty();
    chk("bp_first_grant", 32'(acc_q[0]), 32'd1);
    chk("bp_second_grant", 32'(acc_q[1]), 32'd0);

    // Reset in the middle of a divide discards it.
    send(1'b0, 2'b11, 10'd1000, 10'd7);
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_state_div", 32'(dbg_state), 32'd2);
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", 32'(rsp_result), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_idle", 32'(dbg_state), 32'd0);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
